// File: rtl/conv_encoder_core.sv
// Frame-based convolutional encoder: reads LSB-first info bits from a byte buffer and writes
// one 24-bit softbit word per trellis step. Optional softbit noise: define CONV_ENC_NOISE_EN.
module conv_encoder_core #(
    parameter int SRC_ADDR_W = 12,
    parameter int DST_ADDR_W = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_sync_i,
    input  logic                  frame_start_i,
    input  logic [1:0]            register_num_i,
    input  logic [2:0]            valid_polynomials_i,
    input  logic                  tail_biting_en_i,
    input  logic [7:0]            polynomial1_i,
    input  logic [7:0]            polynomial2_i,
    input  logic [7:0]            polynomial3_i,
    input  logic [7:0]            polynomial4_i,
    input  logic [7:0]            polynomial5_i,
    input  logic [7:0]            polynomial6_i,
    input  logic [11:0]           infobit_length_i,
    input  logic [SRC_ADDR_W-1:0] src_start_addr_i,
    input  logic [DST_ADDR_W-1:0] dst_start_addr_i,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output logic                  src_rd_o,
    output logic [SRC_ADDR_W-1:0] src_addr_o,
    input  logic [7:0]            src_rdata_i,
    output logic                  dst_wr_o,
    output logic [DST_ADDR_W-1:0] dst_addr_o,
    output logic [23:0]           dst_wdata_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRELOAD  = 3'd1;
    localparam logic [2:0] S_PRE_WAIT = 3'd2;
    localparam logic [2:0] S_FETCH    = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_ENCODE   = 3'd5;
    localparam logic [2:0] S_TAIL     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [2:0]            m_q, n_q;
    logic                  tb_q;
    logic [7:0]            poly_q [6];
    logic [11:0]           len_q;
    logic [SRC_ADDR_W-1:0] src_base_q;
    logic [DST_ADDR_W-1:0] dst_addr_q;
    logic [5:0]            hist_q;     // hist_q[k-1] holds sr[k]
    logic [11:0]           bit_idx_q;
    logic [2:0]            cnt_q;      // preload step / tail step
    logic [7:0]            byte_q;

    logic       start_ok;
    logic [2:0] m_in, n_in;
    logic [7:0] mask_in;
    logic [7:0] poly_in [6];

    assign start_ok = (state_q == S_IDLE) && frame_start_i;

    always_comb begin
        m_in       = 3'd6 - {1'b0, register_num_i};
        n_in       = (valid_polynomials_i >= 3'd4) ? 3'd6 : valid_polynomials_i + 3'd2;
        mask_in    = (8'd2 << m_in) - 8'd1;
        poly_in[0] = polynomial1_i;
        poly_in[1] = polynomial2_i;
        poly_in[2] = polynomial3_i;
        poly_in[3] = polynomial4_i;
        poly_in[4] = polynomial5_i;
        poly_in[5] = polynomial6_i;
    end

    logic [11:0] pre_idx;
    logic        pre_zero, pre_last, enc_last, cur_bit;
    logic [7:0]  sr;

    // Preload walks bits L-m..L-1; indices below zero shift in 0 without a read.
    assign pre_idx  = len_q - {9'd0, m_q} + {9'd0, cnt_q};
    assign pre_zero = ({1'b0, len_q} + {10'd0, cnt_q}) < {10'd0, m_q};
    assign pre_last = (cnt_q == m_q - 3'd1);
    assign enc_last = (bit_idx_q == len_q - 12'd1);
    assign cur_bit  = (state_q == S_ENCODE) ? byte_q[bit_idx_q[2:0]] : 1'b0;
    assign sr       = {1'b0, hist_q, cur_bit};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    if (infobit_length_i == 12'd0) state_d = S_FETCH;
                    else if (tail_biting_en_i)     state_d = S_PRELOAD;
                    else                           state_d = S_FETCH;
                end
            end
            S_PRELOAD: begin
                if (!pre_zero)     state_d = S_PRE_WAIT;
                else if (pre_last) state_d = S_FETCH;
            end
            S_PRE_WAIT: state_d = pre_last ? S_FETCH : S_PRELOAD;
            S_FETCH:    state_d = (len_q == 12'd0) ? S_DONE : S_WAIT;
            S_WAIT:     state_d = S_ENCODE;
            S_ENCODE: begin
                if (enc_last)                     state_d = tb_q ? S_DONE : S_TAIL;
                else if (bit_idx_q[2:0] == 3'd7)  state_d = S_FETCH;
            end
            S_TAIL:     if (cnt_q == m_q - 3'd1) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            tb_q       <= 1'b0;
            len_q      <= '0;
            src_base_q <= '0;
            dst_addr_q <= '0;
            hist_q     <= '0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            byte_q     <= '0;
            for (int j = 0; j < 6; j++) poly_q[j] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (frame_start_i) begin
                        m_q        <= m_in;
                        n_q        <= n_in;
                        tb_q       <= tail_biting_en_i;
                        len_q      <= infobit_length_i;
                        src_base_q <= src_start_addr_i;
                        dst_addr_q <= dst_start_addr_i;
                        hist_q     <= '0;
                        bit_idx_q  <= '0;
                        cnt_q      <= '0;
                        for (int j = 0; j < 6; j++) poly_q[j] <= poly_in[j] & mask_in;
                    end
                end
                S_PRELOAD: begin
                    if (pre_zero) begin
                        hist_q <= {hist_q[4:0], 1'b0};
                        cnt_q  <= pre_last ? 3'd0 : cnt_q + 3'd1;
                    end
                end
                S_PRE_WAIT: begin
                    hist_q <= {hist_q[4:0], src_rdata_i[pre_idx[2:0]]};
                    cnt_q  <= pre_last ? 3'd0 : cnt_q + 3'd1;
                end
                S_WAIT: byte_q <= src_rdata_i;
                S_ENCODE: begin
                    hist_q     <= {hist_q[4:0], cur_bit};
                    bit_idx_q  <= bit_idx_q + 12'd1;
                    dst_addr_q <= dst_addr_q + 1'b1;
                end
                S_TAIL: begin
                    hist_q     <= {hist_q[4:0], 1'b0};
                    cnt_q      <= cnt_q + 3'd1;
                    dst_addr_q <= dst_addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_ENC_NOISE_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci form of x^16+x^14+x^13+x^11+1
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge clk_i) begin
        if (rst_sync_i)    lfsr_q <= 16'hACE1;
        else if (start_ok) lfsr_q <= 16'hACE1;
        else if (dst_wr_o) lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
`endif

    logic [23:0] word;

    always_comb begin
        word = '0;
        for (int j = 0; j < 6; j++) begin
            if (3'(j) < n_q) begin
`ifdef CONV_ENC_NOISE_EN
                word[4*j +: 4] = (^(poly_q[j] & sr)) ? 4'd9 + {2'b00, lfsr_q[2*j +: 2]}
                                                     : 4'd7 - {2'b00, lfsr_q[2*j +: 2]};
`else
                word[4*j +: 4] = (^(poly_q[j] & sr)) ? 4'h9 : 4'h7;
`endif
            end
        end
    end

    assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done_o = (state_q == S_DONE);
    assign src_rd_o     = ((state_q == S_PRELOAD) && !pre_zero) ||
                          ((state_q == S_FETCH) && (len_q != 12'd0));
    assign dst_wr_o     = (state_q == S_ENCODE) || (state_q == S_TAIL);
    assign dst_addr_o   = dst_addr_q;
    assign dst_wdata_o  = dst_wr_o ? word : 24'd0;

    always_comb begin
        src_addr_o = '0;
        if (src_rd_o) begin
            if (state_q == S_PRELOAD) src_addr_o = src_base_q + SRC_ADDR_W'(pre_idx >> 3);
            else                      src_addr_o = src_base_q + SRC_ADDR_W'(bit_idx_q >> 3);
        end
    end

endmodule
